// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional MDU_DIV_EARLY_TERM_EN: skip iteration when |a| < |b|.
module mdu_hilo #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic        neg_q;
  logic        neg_r;

  logic        accept;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        mul_sgn;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] mul_res;
  logic [32:0] sh;
  logic        ge;
  logic [31:0] sub;
  logic        early;

  assign accept  = valid_i & ~flush_i & (state == IDLE);
  assign a_neg   = (op_i == 3'd2) & a_i[31];
  assign b_neg   = (op_i == 3'd2) & b_i[31];
  assign a_mag   = a_neg ? -a_i : a_i;
  assign b_mag   = b_neg ? -b_i : b_i;

  // Sign-extend for MULT so the low 64 bits of the product are exact.
  assign mul_sgn = (op_i == 3'd0);
  assign ext_a   = {{32{mul_sgn & a_i[31]}}, a_i};
  assign ext_b   = {{32{mul_sgn & b_i[31]}}, b_i};
  assign mul_res = ext_a * ext_b;

  assign sh  = {rem, quo[31]};
  assign ge  = sh >= {1'b0, dvs};
  assign sub = sh[31:0] - dvs;

`ifdef MDU_DIV_EARLY_TERM_EN
  assign early = (b_i != 32'd0) & (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      prod   <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done_o <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            unique case (op_i)
              3'd0, 3'd1: begin
                prod  <= mul_res;
                cnt   <= 5'(MUL_LAT - 1);
                state <= MUL;
              end
              3'd2, 3'd3: begin
                dvs <= b_mag;
                if (b_i == 32'd0) begin
                  quo   <= 32'hFFFF_FFFF;
                  rem   <= a_i;
                  neg_q <= 1'b0;
                  neg_r <= 1'b0;
                  state <= FIX;
                end else if (early) begin
                  quo   <= '0;
                  rem   <= a_i;
                  neg_q <= 1'b0;
                  neg_r <= 1'b0;
                  state <= FIX;
                end else begin
                  quo   <= a_mag;
                  rem   <= '0;
                  neg_q <= a_neg ^ b_neg;
                  neg_r <= a_neg;
                  cnt   <= 5'd31;
                  state <= DIV;
                end
              end
              3'd4: hi_o <= a_i;
              3'd5: lo_o <= a_i;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (flush_i) begin
            state <= IDLE;
          end else if (cnt == 5'd0) begin
            {hi_o, lo_o} <= prod;
            done_o       <= 1'b1;
            state        <= IDLE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        DIV: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            rem <= ge ? sub : sh[31:0];
            quo <= {quo[30:0], ge};
            if (cnt == 5'd0) begin
              state <= FIX;
            end else begin
              cnt <= cnt - 5'd1;
            end
          end
        end
        FIX: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            lo_o   <= neg_q ? -quo : quo;
            hi_o   <= neg_r ? -rem : rem;
            done_o <= 1'b1;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in the execute stage beside the ALU and receives the same decoded operands.
- Feeds HI/LO to the downstream MFHI/MFLO path.
- Stalls the pipeline via busy_o while an operation is in flight; supports MULT, MULTU, DIV, DIVU, MTHI, MTLO.

Parameters:
MUL_LAT, 2, cycles from acceptance to HI/LO update for MULT/MULTU; legal range 1..8

Ports:
clk  input  1  clock; all state updates on rising edge
resetn  input  1  asynchronous, active-low reset
valid_i  input  1  operation request this cycle
op_i  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 = no-op
a_i  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source)
b_i  input  32  rt operand (divisor / multiplier)
flush_i  input  1  pipeline flush (exception/branch squash); aborts in-flight op
busy_o  output  1  op in flight; upstream must hold the pipeline
done_o  output  1  one-cycle pulse: HI/LO just updated by MULT/DIV
hi_o  output  32  registered HI
lo_o  output  32  registered LO

Behaviour:
- Reset (async, resetn=0): hi_o=0, lo_o=0, busy_o=0, done_o=0, state=IDLE, counter=0.
  - Reset mid-operation discards the operation.
- States:
  - IDLE: the only state that accepts requests.
  - MUL: counts down MUL_LAT.
  - DIV: 32 iterations.
  - FIX: sign correction, 1 cycle.
- Acceptance: valid_i=1 and state=IDLE and flush_i=0 at edge N.
  - valid_i while busy_o=1 is ignored.
  - flush_i and valid_i together in IDLE: flush wins; request dropped.
- MTHI/MTLO: at edge N, hi_o (MTHI) or lo_o (MTLO) := a_i. No busy, no done_o. State stays IDLE.
- MULT/MULTU: full 64-bit product.
  - MULT: signed x signed. MULTU: unsigned x unsigned.
  - busy_o=1 from edge N to edge N+MUL_LAT.
  - At edge N+MUL_LAT: {hi_o,lo_o} := product, busy_o=0, done_o=1 for one cycle.
- DIV/DIVU: restoring radix-2 divide on magnitudes, one quotient bit per cycle.
  - Operands latched at edge N; later changes to a_i/b_i have no effect.
  - Signed: quotient negative iff a[31]^b[31]; remainder takes the sign of a.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0.
  - Normal path: DIV state edges N+1..N+32, FIX at N+33. HI/LO updated and done_o=1 after edge N+33; busy_o=0 in that same cycle.
  - lo_o=quotient, hi_o=remainder.
  - Divide by zero (b_i=0): no iteration. At edge N+1: lo_o=0xFFFFFFFF, hi_o=a_i (as latched), done_o=1.
- busy_o and done_o are never both 1.
- done_o falls the cycle after it rises unless a new op completes.
- flush_i=1 while busy: at the next edge, state=IDLE, busy_o=0, done_o=0, HI/LO unchanged.
  - flush_i in the completion cycle (done_o=1) does not undo the already-committed HI/LO.
- op_i=6/7 with valid_i: no effect.
- Back-to-back: a new request may be accepted in the cycle done_o=1, since state is IDLE.

Optional Feature:
MDU_DIV_EARLY_TERM_EN
- Defined: if divisor != 0 and |a| < |b| (magnitudes, after sign handling for DIV), skip iteration.
  - At edge N+1: lo_o=0, hi_o=a (original signed value), done_o=1.
- Not defined: such divides take the full N+33 path with identical result values.
- Divide-by-zero behaviour is the same either way.

Test Plan:
- Reset then MTHI a=0x12345678, next cycle MTLO a=0x9ABCDEF0 -> hi_o=0x12345678, lo_o=0x9ABCDEF0; busy_o never 1, done_o never 1.
- MULT a=0xFFFFFFFE (-2), b=3, MUL_LAT=2 -> busy 2 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA, done_o pulse. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> after 33 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=7 -> lo=14, hi=2.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU b=0, a=55 -> at N+1 lo=0xFFFFFFFF, hi=55, done_o=1.
- DIVU a=100, b=7, flush_i at cycle N+10 -> busy_o=0 next cycle, HI/LO keep prior values, no done_o. New MULTU 6x7 accepted immediately -> lo=42, hi=0.
- DIVU a=3, b=10 -> with MDU_DIV_EARLY_TERM_EN done at N+1; without it done at N+33. Both give lo=0, hi=3. Async reset asserted mid-DIV -> all outputs 0 immediately.
